// File: rtl/sim_clock_divider_if.sv
// sim_clock_divider_if: configuration request port of the clock divider
interface sim_clock_divider_if #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 8
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CW-1:0]        cfg_chan;
   logic [CNT_WIDTH-1:0] cfg_div;
   logic [CNT_WIDTH-1:0] cfg_phase;
   logic                 cfg_err;
   modport master (output cfg_valid, cfg_chan, cfg_div, cfg_phase, input cfg_ready, cfg_err);
   modport slave  (input cfg_valid, cfg_chan, cfg_div, cfg_phase, output cfg_ready, cfg_err);
endinterface

// File: rtl/sim_clock_divider.sv
// sim_clock_divider: multi-channel programmable integer clock divider with
// phase offset, glitch-free enable and reconfiguration at safe boundaries
module sim_clock_divider #(
   parameter int CHANNELS    = 4,
   parameter int CNT_WIDTH   = 8,
   parameter int DEFAULT_DIV = 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   sim_clock_divider_if.slave  cfg,
   input  logic [CHANNELS-1:0] en_i,
   output logic [CHANNELS-1:0] clk_o,
   output logic [CHANNELS-1:0] locked_o
);
   localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
   localparam logic [CW:0] NCH = (CW+1)'(CHANNELS);
   logic [CHANNELS-1:0] busy;
   logic                in_range;
   assign in_range = {1'b0, cfg.cfg_chan} < NCH;
   assign cfg.cfg_ready = ~|busy;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) cfg.cfg_err <= 1'b0;
      else cfg.cfg_err <= cfg.cfg_valid && !in_range;
   for (genvar g = 0; g < CHANNELS; g++) begin : ch
      logic [CNT_WIDTH-1:0] div, cnt, pend_div, pend_phase;
      logic                 out, run, pend, locked, wrap, fall, acc;
      assign wrap = cnt == div - 1'b1;
      assign fall = run && out && wrap;
      assign acc = cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_chan == CW'(g);
      assign busy[g] = pend && cfg.cfg_chan == CW'(g);
      assign clk_o[g] = out;
      assign locked_o[g] = locked;
      // Reconfiguration and disable only act at a falling edge or while idle,
      // so no high pulse is ever shortened.
      always_ff @(posedge clk_i or negedge rst_ni)
         if (!rst_ni) begin
            div <= CNT_WIDTH'(DEFAULT_DIV);
            cnt <= '0;
            out <= 1'b0;
            run <= 1'b0;
            pend <= 1'b0;
            pend_div <= '0;
            pend_phase <= '0;
            locked <= 1'b0;
         end else begin
            if (acc) begin
               pend <= 1'b1;
               pend_div <= cfg.cfg_div;
               pend_phase <= cfg.cfg_phase;
            end
            if (pend && (fall || !run)) begin
               div <= pend_div;
               cnt <= pend_phase < pend_div ? pend_phase : '0;
               out <= 1'b0;
               locked <= 1'b0;
               pend <= 1'b0;
               run <= pend_div != '0 && en_i[g];
            end else if (!run) begin
               run <= en_i[g] && div != '0;
               cnt <= '0;
            end else if (fall && !en_i[g]) begin
               run <= 1'b0;
               cnt <= '0;
               out <= 1'b0;
               locked <= 1'b0;
            end else if (wrap) begin
               cnt <= '0;
               out <= ~out;
               if (out) locked <= 1'b1;
            end else cnt <= cnt + 1'b1;
         end
   end
endmodule

// File: tb/tb_sim_clock_divider.sv
// tb_sim_clock_divider: directed cycle-exact checks of division, phase,
// enable/disable, reconfiguration, error pulse and async reset
module tb_sim_clock_divider;
   localparam int CH = 3;
   localparam int CWD = 8;
   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic [CH-1:0] en = '0;
   logic [CH-1:0] clk_o, locked_o;
   int            nvec = 0;
   int            nerr = 0;
   sim_clock_divider_if #(.CHANNELS(CH), .CNT_WIDTH(CWD)) cfg ();
   sim_clock_divider #(.CHANNELS(CH), .CNT_WIDTH(CWD), .DEFAULT_DIV(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cfg(cfg), .en_i(en), .clk_o(clk_o), .locked_o(locked_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask
   task automatic req(input logic [1:0] chan, input logic [7:0] div, input logic [7:0] phase);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_chan = chan;
      cfg.cfg_div = div;
      cfg.cfg_phase = phase;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      cfg.cfg_valid = 1'b0;
      cfg.cfg_chan = '0;
      cfg.cfg_div = '0;
      cfg.cfg_phase = '0;
      #2;
      chk("rst_clk", 32'(clk_o), 0);
      chk("rst_locked", 32'(locked_o), 0);
      chk("rst_ready", 32'(cfg.cfg_ready), 1);
      chk("rst_err", 32'(cfg.cfg_err), 0);
      en = 3'b111;
      tick(2);
      rst_ni = 1'b1;
      tick(1);
      chk("start_idle", 32'(clk_o), 0);
      tick(1);
      chk("div1_rise", 32'(clk_o), 3'b111);
      chk("div1_nolock", 32'(locked_o), 0);
      tick(1);
      chk("div1_fall", 32'(clk_o), 0);
      chk("div1_lock", 32'(locked_o), 3'b111);
      tick(1);
      req(2'd1, 8'd3, 8'd0);
      chk("ch1_ready_pre", 32'(cfg.cfg_ready), 1);
      tick(1);
      cfg.cfg_valid = 1'b0;
      chk("ch1_ready_pend", 32'(cfg.cfg_ready), 0);
      chk("ch1_old_fall", 32'(clk_o[1]), 0);
      tick(1);
      chk("ch1_held_high", 32'(clk_o[1]), 1);
      chk("ch1_ready_pend2", 32'(cfg.cfg_ready), 0);
      tick(1);
      chk("ch1_apply_clk", 32'(clk_o[1]), 0);
      chk("ch1_apply_lock", 32'(locked_o[1]), 0);
      chk("ch1_ready_back", 32'(cfg.cfg_ready), 1);
      tick(2);
      chk("ch1_low2", 32'(clk_o[1]), 0);
      tick(1);
      chk("ch1_rise", 32'(clk_o[1]), 1);
      chk("ch1_lock_lo", 32'(locked_o[1]), 0);
      tick(2);
      chk("ch1_high3", 32'(clk_o[1]), 1);
      chk("ch1_lock_lo2", 32'(locked_o[1]), 0);
      tick(1);
      chk("ch1_fall", 32'(clk_o[1]), 0);
      chk("ch1_lock", 32'(locked_o[1]), 1);
      en[2] = 1'b0;
      tick(2);
      chk("ch2_dis_clk", 32'(clk_o[2]), 0);
      chk("ch2_dis_lock", 32'(locked_o[2]), 0);
      req(2'd2, 8'd4, 8'd2);
      tick(1);
      cfg.cfg_valid = 1'b0;
      en[2] = 1'b1;
      chk("ch2_ready_pend", 32'(cfg.cfg_ready), 0);
      tick(1);
      chk("ch2_apply_clk", 32'(clk_o[2]), 0);
      chk("ch2_ready_back", 32'(cfg.cfg_ready), 1);
      tick(1);
      chk("ch2_ph_low", 32'(clk_o[2]), 0);
      tick(1);
      chk("ch2_ph_rise", 32'(clk_o[2]), 1);
      chk("ch2_ph_nolock", 32'(locked_o[2]), 0);
      tick(3);
      chk("ch2_high4", 32'(clk_o[2]), 1);
      tick(1);
      chk("ch2_fall", 32'(clk_o[2]), 0);
      chk("ch2_lock", 32'(locked_o[2]), 1);
      req(2'd2, 8'd4, 8'd5);
      tick(1);
      cfg.cfg_valid = 1'b0;
      tick(7);
      chk("clamp_apply_clk", 32'(clk_o[2]), 0);
      chk("clamp_apply_lock", 32'(locked_o[2]), 0);
      tick(3);
      chk("clamp_low", 32'(clk_o[2]), 0);
      tick(1);
      chk("clamp_rise", 32'(clk_o[2]), 1);
      tick(1);
      en[2] = 1'b0;
      tick(2);
      chk("dis_high_kept", 32'(clk_o[2]), 1);
      tick(1);
      chk("dis_fall", 32'(clk_o[2]), 0);
      chk("dis_unlock", 32'(locked_o[2]), 0);
      tick(3);
      chk("dis_hold_low", 32'(clk_o[2]), 0);
      en[2] = 1'b1;
      tick(4);
      chk("reen_low", 32'(clk_o[2]), 0);
      tick(1);
      chk("reen_rise", 32'(clk_o[2]), 1);
      req(2'd1, 8'd5, 8'd0);
      chk("pend1_ready_pre", 32'(cfg.cfg_ready), 1);
      tick(1);
      cfg.cfg_div = 8'd7;
      chk("pend1_second_blocked", 32'(cfg.cfg_ready), 0);
      tick(1);
      cfg.cfg_valid = 1'b0;
      chk("pend1_apply_ready", 32'(cfg.cfg_ready), 1);
      chk("pend1_apply_clk", 32'(clk_o[1]), 0);
      chk("pend1_apply_lock", 32'(locked_o[1]), 0);
      tick(4);
      chk("div5_low", 32'(clk_o[1]), 0);
      tick(1);
      chk("div5_rise", 32'(clk_o[1]), 1);
      req(2'd3, 8'd9, 8'd0);
      chk("oor_ready", 32'(cfg.cfg_ready), 1);
      tick(1);
      cfg.cfg_valid = 1'b0;
      chk("oor_err", 32'(cfg.cfg_err), 1);
      tick(1);
      chk("oor_err_clear", 32'(cfg.cfg_err), 0);
      chk("oor_ch1_intact", 32'(clk_o[1]), 1);
      req(2'd1, 8'd9, 8'd0);
      tick(1);
      cfg.cfg_valid = 1'b0;
      chk("pre_rst_pend", 32'(cfg.cfg_ready), 0);
      chk("pre_rst_high", 32'(clk_o[1]), 1);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("async_rst_clk", 32'(clk_o), 0);
      chk("async_rst_lock", 32'(locked_o), 0);
      chk("async_rst_ready", 32'(cfg.cfg_ready), 1);
      #2;
      rst_ni = 1'b1;
      tick(2);
      chk("post_rst_rise", 32'(clk_o), 3'b111);
      tick(1);
      chk("post_rst_fall", 32'(clk_o), 0);
      chk("post_rst_lock", 32'(locked_o), 3'b111);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
